// File: rtl/microwave_cook_sequencer.sv
// microwave_cook_sequencer: BCD cook timer with power duty cycling, pause/resume and a completion beep.
module microwave_cook_sequencer (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       load,
  input  logic [3:0] load_min,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic [3:0] power,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done_beep,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_q, min_d, ten_q, ten_d, one_q, one_d;
  logic [3:0] phase_q, phase_d, power_q, power_d;
  logic [1:0] beep_q, beep_d;
  logic       load_ok, halt, last, b1, b2;
  logic [3:0] one_dec, ten_dec, min_dec, pwr_in;

  assign load_ok = load_min <= 4'd9 && load_sec_tens <= 4'd5 && load_sec_ones <= 4'd9 &&
                   |{load_min, load_sec_tens, load_sec_ones};
  assign pwr_in  = (power == 4'd0 || power > 4'd10) ? 4'd10 : power;
  assign halt    = stop || !door_closed;
  assign last    = min_q == 4'd0 && ten_q == 4'd0 && one_q == 4'd1;
  assign b1      = one_q == 4'd0;
  assign b2      = b1 && ten_q == 4'd0;
  assign one_dec = b1 ? 4'd9 : one_q - 4'd1;
  assign ten_dec = b1 ? (ten_q == 4'd0 ? 4'd5 : ten_q - 4'd1) : ten_q;
  assign min_dec = b2 ? min_q - 4'd1 : min_q;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    ten_d   = ten_q;
    one_d   = one_q;
    phase_d = phase_q;
    power_d = power_q;
    beep_d  = beep_q;
    case (state_q)
      COOK: begin
        if (halt) state_d = PAUSE;
        else if (tick_1hz) begin
          one_d   = one_dec;
          ten_d   = ten_dec;
          min_d   = min_dec;
          phase_d = phase_q == 4'd9 ? 4'd0 : phase_q + 4'd1;
          if (last) begin
            state_d = DONE;
            beep_d  = 2'd0;
          end
        end
      end
      DONE: begin
        if (halt) state_d = IDLE;
        else if (tick_1hz) begin
          beep_d  = beep_q + 2'd1;
          state_d = beep_q == 2'd2 ? IDLE : DONE;
        end
      end
      IDLE, READY, PAUSE: begin
        if (stop && state_q != IDLE) begin
          state_d = IDLE;
          {min_d, ten_d, one_d} = 12'h000;
        end else if (start && door_closed && state_q != IDLE) begin
          state_d = COOK;
          phase_d = state_q == READY ? 4'd0 : phase_q;
        end else if (load && load_ok) begin
          state_d = READY;
          min_d   = load_min;
          ten_d   = load_sec_tens;
          one_d   = load_sec_ones;
          power_d = pwr_in;
        end
      end
      default: begin
        state_d = IDLE;
        {min_d, ten_d, one_d} = 12'h000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      min_q   <= 4'd0;
      ten_q   <= 4'd0;
      one_q   <= 4'd0;
      phase_q <= 4'd0;
      power_q <= 4'd10;
      beep_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
      phase_q <= phase_d;
      power_q <= power_d;
      beep_q  <= beep_d;
    end
  end

  // door_closed is the only live input on the magnetron path, as a safety interlock
  assign mag_on    = state_q == COOK && door_closed && phase_q < power_q;
  assign done_beep = state_q == DONE;
  assign mins      = min_q;
  assign sec_tens  = ten_q;
  assign sec_ones  = one_q;
  assign state     = state_q;
endmodule

// File: doc/microwave_cook_sequencer.md
MICROWAVE_COOK_SEQUENCER -- requirements
Module: microwave_cook_sequencer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-clk-wide pulse, once per second.
- start  in  1  one-clk-wide start request.
- stop  in  1  one-clk-wide stop/cancel request.
- door_closed  in  1  high = door closed.
- load  in  1  one-clk-wide time/power load strobe.
- load_min  in  4  BCD minutes, 0-9.
- load_sec_tens  in  4  BCD seconds tens, 0-5.
- load_sec_ones  in  4  BCD seconds ones, 0-9.
- power  in  4  power level, 1-10.
- mins  out  4  remaining minutes, BCD.
- sec_tens  out  4  remaining seconds tens, BCD.
- sec_ones  out  4  remaining seconds ones, BCD.
- mag_on  out  1  magnetron enable.
- done_beep  out  1  cook-complete indicator.
- state  out  3  current FSM state code.

Function
REQ-002 The FSM SHALL have exactly these states and codes: IDLE=000, READY=001, COOK=010, PAUSE=011, DONE=100. All other codes SHALL return to IDLE on the next edge.
REQ-003 Input priority within any one cycle SHALL be: clear > door open / stop > start > load > tick_1hz.
REQ-004 A load SHALL be accepted only in IDLE, READY or PAUSE, and only when the time is valid: every digit <=9, sec_tens <=5, and the time is not 0:00. An accepted load SHALL capture the time and power on that edge and enter READY. A rejected load SHALL change nothing.
REQ-005 Power is captured at load. Values 0 or >10 SHALL be stored as 10.
REQ-006 READY: start with door_closed=1 SHALL enter COOK and clear the phase counter. Start with door_closed=0 SHALL be ignored. Stop SHALL enter IDLE and zero the time.
REQ-007 COOK, on tick_1hz: decrement the time as BCD.
- sec_ones 0 borrows to 9.
- sec_tens 0 borrows to 5.
- mins decrements on a seconds borrow.
- The phase counter advances 0..9, then wraps to 0.
REQ-008 COOK: a tick that takes the time from 0:01 to 0:00 SHALL enter DONE on the same edge.
REQ-009 COOK: stop, or door_closed=0, SHALL enter PAUSE on the next edge. A tick in that same cycle SHALL be ignored, so time and phase are held.
REQ-010 COOK: load SHALL be ignored.
REQ-011 PAUSE: time, phase and power SHALL be held.
- start with door_closed=1 SHALL enter COOK, resuming the held phase.
- stop SHALL enter IDLE and zero the time.
REQ-012 mag_on = (state==COOK) AND door_closed AND (phase < power). With power=10, mag_on SHALL be continuous through COOK. With power=3, it SHALL be on for 3 of every 10 ticks.
REQ-013 The only input allowed in the mag_on path is door_closed, as a safety gate. All other terms SHALL come from registers.
REQ-014 DONE:
- done_beep=1 and time=0:00.
- A 2-bit counter SHALL return the block to IDLE on the 3rd tick_1hz after entry.
- stop, or door_closed=0, SHALL return to IDLE on the next edge.
- start and load SHALL be ignored.
REQ-015 done_beep SHALL be 0 in every state except DONE.
REQ-016 IDLE: time SHALL read 0:00. start and stop SHALL be ignored.

Reset
REQ-017 clear=1 at an edge SHALL force the following, from any state including mid-cook:
- state=IDLE.
- mins=sec_tens=sec_ones=0.
- phase=0, power=10, beep counter=0.
- mag_on=0 and done_beep=0 from that edge on.
REQ-018 Reset SHALL be synchronous only. clear SHALL have no effect between clock edges.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Basic cook: load 0:12, power=10, door closed, start, 12 ticks -> mag_on=1 throughout COOK; time steps 0:12, 0:11 … 0:00; enters DONE; done_beep=1; after 3 more ticks, IDLE.
- Borrow: load 1:00, start, 1 tick -> 0:59; load 9:59 is accepted; load 0:60 and load 0:00 are rejected (state unchanged).
- Power duty: load 0:20, power=3, start, 20 ticks -> mag_on high during ticks 0-2 and 10-12 of the phase only; power=0 behaves as 10.
- Door/stop: COOK at 0:30, door_closed=0 in the same cycle as a tick -> mag_on=0 immediately; PAUSE holds 0:30. Close door, start -> resumes. Stop in PAUSE -> IDLE, 0:00.
- Priority: start and stop in the same cycle in READY -> IDLE. start with door open -> stays READY.
- Reset mid-cook: clear during COOK at 4:37 -> next cycle IDLE, 0:00, mag_on=0, done_beep=0.
